// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: program memory with a side load port, fixed-latency
// in-order read pipeline feeding a small response FIFO, with flush and outstanding-count flow control.
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [31:0]   NOP   = 32'h0000_0013;
  localparam logic [CW-1:0] QMAX  = CW'(QDEPTH);
  localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [LATENCY-1:0] pv_q, pv_d;
  logic [LATENCY-1:0] pe_q;
  logic [31:0]        pi_q [LATENCY];

  logic [31:0]       fi_q [QDEPTH];
  logic [QDEPTH-1:0] fe_q;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     fcnt_q, fcnt_d, ocnt_q, ocnt_d;

  logic          req_err, load_ok, accept, pop, push;
  logic [AW-1:0] req_idx, load_idx;
  logic          unused_load_lsb;

  assign req_idx         = req_addr[AW+1:2];
  assign load_idx        = load_addr[AW+1:2];
  assign req_err         = (|req_addr[31:AW+2]) || (req_addr[1:0] != 2'b00);
  assign load_ok         = load_en && !(|load_addr[31:AW+2]);
  assign unused_load_lsb = ^load_addr[1:0];

  // Ready depends only on the registered count, never on rsp_ready.
  assign req_ready = !flush && (ocnt_q < QMAX);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fcnt_q != '0);
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign push      = pv_q[LATENCY-1] && !flush;
  assign rsp_instr = rsp_valid ? fi_q[rd_q] : '0;
  assign rsp_err   = rsp_valid && fe_q[rd_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pv_d   = '0;
    ocnt_d = ocnt_q;
    fcnt_d = fcnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    if (flush) begin
      ocnt_d = '0;
      fcnt_d = '0;
      rd_d   = '0;
      wr_d   = '0;
    end else begin
      pv_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) pv_d[i] = pv_q[i-1];
      if (accept && !pop)      ocnt_d = ocnt_q + CW'(1);
      else if (!accept && pop) ocnt_d = ocnt_q - CW'(1);
      if (push && !pop)        fcnt_d = fcnt_q + CW'(1);
      else if (!push && pop)   fcnt_d = fcnt_q - CW'(1);
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= '0;
      ocnt_q <= '0;
      fcnt_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      pv_q   <= pv_d;
      ocnt_q <= ocnt_d;
      fcnt_q <= fcnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  // Read samples the pre-write array, so a same-edge load+read returns old data.
  always_ff @(posedge clk) begin
    if (load_ok) mem_q[load_idx] <= load_data;
    if (accept) begin
      if (req_err) pi_q[0] <= NOP;
      else         pi_q[0] <= mem_q[req_idx];
      pe_q[0] <= req_err;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pi_q[i] <= pi_q[i-1];
      pe_q[i] <= pe_q[i-1];
    end
    if (push) begin
      fi_q[wr_q] <= pi_q[LATENCY-1];
      fe_q[wr_q] <= pe_q[LATENCY-1];
    end
  end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: scoreboard of expected responses plus
// a table of address vectors and directed sequences for latency, back-pressure, flush and reset.
module tb_imem_fetch_responder;
  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;
  localparam int QDEPTH      = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic        flush, load_en;
  logic [31:0] req_addr, rsp_instr, load_addr, load_data;

  always #5 clk = ~clk;

  imem_fetch_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] bmem [DEPTH_WORDS];
  rsp_t        sbq [$];
  rsp_t        ovr;
  bit          ovr_en = 1'b0;
  bit          last_acc;
  vec_t        vt [13];
  logic [31:0] old_word;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic rsp_t model(input logic [31:0] a);
    rsp_t r;
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH_WORDS)) begin
      r.instr = NOP;
      r.err   = 1'b1;
    end else begin
      r.instr = bmem[a[9:2]];
      r.err   = 1'b0;
    end
    return r;
  endfunction

  // Called with inputs settled, mid-cycle; resolves this edge's handshakes, then advances one clock.
  task automatic step();
    rsp_t e;
    if (!flush && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got %h with no request pending at %0t", rsp_instr, $time);
      end else begin
        e = sbq.pop_front();
        check("rsp_instr", rsp_instr, e.instr);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    last_acc = req_valid && req_ready;
    if (flush) sbq.delete();
    else if (last_acc) sbq.push_back(ovr_en ? ovr : model(req_addr));
    if (load_en && load_addr < 32'(4 * DEPTH_WORDS)) bmem[load_addr[9:2]] = load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    check("issue_accepted", 32'(last_acc), 1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < budget && sbq.size() != 0; i++) step();
    check("drain_empty", 32'(sbq.size()), 0);
    repeat (3) begin
      check("no_stale", 32'(rsp_valid), 0);
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_instr", rsp_instr, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH_WORDS; i++) begin
      load_en   = 1'b1;
      load_addr = 32'(4 * i);
      load_data = (i == 0) ? 32'h0050_0093 : $urandom;
      step();
    end
    load_en = 1'b0;

    // Reset pulse between edges; memory contents survive, then first-request latency.
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_req_ready", 32'(req_ready), 1);
    rsp_ready = 1'b1;
    issue(32'h0);
    check("lat_T0", 32'(rsp_valid), 0);
    step();
    check("lat_T1", 32'(rsp_valid), 0);
    step();
    check("lat_T2", 32'(rsp_valid), 1);
    check("lat_instr", rsp_instr, 32'h0050_0093);
    drain(10);

    // Back-pressure: two outstanding fills the responder; head holds; no accept in the pop cycle.
    rsp_ready = 1'b0;
    issue(32'h0);
    issue(32'h4);
    check("full_req_ready", 32'(req_ready), 0);
    repeat (3) begin
      step();
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_instr", rsp_instr, bmem[0]);
      check("hold_err", 32'(rsp_err), 0);
    end
    req_valid = 1'b1;
    req_addr  = 32'h8;
    step();
    check("full_no_accept", 32'(last_acc), 0);
    rsp_ready = 1'b1;
    check("pop_cycle_not_ready", 32'(req_ready), 0);
    step();
    check("pop_cycle_no_accept", 32'(last_acc), 0);
    check("after_pop_ready", 32'(req_ready), 1);
    step();
    check("third_accepted", 32'(last_acc), 1);
    drain(10);

    // Table of addresses: in-order stream plus error and boundary cases.
    for (int i = 0; i < 8; i++) vt[i] = '{32'(4 * i), bmem[i], 1'b0};
    vt[8]  = '{32'h0000_0002, NOP, 1'b1};
    vt[9]  = '{32'h0000_0400, NOP, 1'b1};
    vt[10] = '{32'h0000_03FC, bmem[255], 1'b0};
    vt[11] = '{32'hFFFF_FFFC, NOP, 1'b1};
    vt[12] = '{32'h0000_0401, NOP, 1'b1};
    rsp_ready = 1'b1;
    ovr_en = 1'b1;
    foreach (vt[k]) begin
      req_valid = 1'b1;
      req_addr  = vt[k].addr;
      ovr.instr = vt[k].instr;
      ovr.err   = vt[k].err;
      last_acc  = 1'b0;
      for (int n = 0; n < 20 && !last_acc; n++) step();
      check("vec_accepted", 32'(last_acc), 1);
    end
    ovr_en = 1'b0;
    drain(20);

    // Flush with two in flight and a request pending.
    rsp_ready = 1'b0;
    issue(32'h10);
    issue(32'h14);
    req_valid = 1'b1;
    req_addr  = 32'h18;
    flush     = 1'b1;
    check("flush_not_ready", 32'(req_ready), 0);
    step();
    check("flush_no_accept", 32'(last_acc), 0);
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_valid_low", 32'(rsp_valid), 0);
    rsp_ready = 1'b1;
    repeat (4) begin
      step();
      check("flush_no_stale", 32'(rsp_valid), 0);
    end
    issue(32'h1C);
    check("flush_lat_T0", 32'(rsp_valid), 0);
    step();
    check("flush_lat_T1", 32'(rsp_valid), 0);
    step();
    check("flush_lat_T2", 32'(rsp_valid), 1);
    drain(10);

    // Asynchronous reset with two outstanding.
    rsp_ready = 1'b0;
    issue(32'h20);
    issue(32'h24);
    step();
    check("pre_rst_valid", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 0);
    check("async_rst_instr", rsp_instr, 0);
    sbq.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_req_ready", 32'(req_ready), 1);
    rsp_ready = 1'b1;
    repeat (4) begin
      step();
      check("rst_no_stale", 32'(rsp_valid), 0);
    end

    // Same-word load and read on one edge returns the old word; later read sees the new one.
    old_word  = bmem[12];
    load_en   = 1'b1;
    load_addr = 32'h30;
    load_data = old_word ^ 32'hDEAD_BEEF;
    issue(32'h30);
    load_en = 1'b0;
    check("collision_model_old", sbq.size() > 0 ? sbq[0].instr : 32'hX, old_word);
    drain(10);
    issue(32'h30);
    drain(10);

    // Out-of-range load must be dropped, not alias onto word 0.
    load_en   = 1'b1;
    load_addr = 32'h400;
    load_data = ~bmem[0];
    step();
    load_en = 1'b0;
    issue(32'h0);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
